// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle RISC-V control path.
// Covers state encodings, opcodes and datapath mux/ALU encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control-path bundle between the datapath (master) and the controller (slave).
interface multicycle_controller_if #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
);
  logic [6:0]         op;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         imm_src;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;
  logic [CNT_W-1:0]   instret;

  modport master (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_op, state_o, instret
  );

  modport slave (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, illegal_op, state_o, instret
  );
endinterface

// File: rtl/multicycle_controller_imm_src.sv
// Combinational opcode-to-immediate-format map, shared with the single-cycle core.
module imm_src_decode
  import mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RISC-V core plus retired-instruction counter.
// Define MC_JAL_EN to add the JAL state; otherwise jal decodes as illegal.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_controller_if.slave bus
);
  state_t           state_reg, state_next, eff_state;
  logic [CNT_W-1:0] instret_reg;
  logic             pc_update, branch, retire;

  imm_src_decode u_imm (.op(bus.op), .imm_src(bus.imm_src));

  // While reset is held the outputs present the FETCH control word.
  assign eff_state   = reset ? S_FETCH : state_reg;
  assign bus.state_o = STATE_W'(eff_state);
  assign bus.instret = instret_reg;
  assign bus.pc_write = pc_update | (branch & bus.zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next     = eff_state;
    pc_update      = 1'b0;
    branch         = 1'b0;
    retire         = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.illegal_op = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    bus.alu_op     = ALUOP_ADD;
    case (eff_state)
      S_FETCH: begin
        bus.ir_write   = bus.mem_ready;
        pc_update      = bus.mem_ready;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALURESULT;
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        // Unknown or unsupported opcodes fall to default and abort the instruction.
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
`ifdef MC_JAL_EN
          OP_JAL:       state_next = S_JAL;
`endif
          default: begin
            bus.illegal_op = 1'b1;
            state_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        state_next    = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = RES_DATA;
        bus.reg_write  = 1'b1;
        retire         = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_RS2;
        bus.alu_op    = ALUOP_FUNCT;
        state_next    = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_FUNCT;
        state_next    = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        pc_update     = 1'b1;
        state_next    = S_ALUWB;
      end
`endif
      S_BEQ: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_RS2;
        bus.alu_op    = ALUOP_SUB;
        branch        = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-cycle expected states/control words are queued per instruction, then checked.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.STATE_W(4), .CNT_W(32)) bus ();
  multicycle_controller_if #(.STATE_W(4), .CNT_W(3))  bus3 ();

  assign bus3.op        = bus.op;
  assign bus3.zero      = bus.zero;
  assign bus3.mem_ready = bus.mem_ready;

  multicycle_controller #(.STATE_W(4), .CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  multicycle_controller #(.STATE_W(4), .CNT_W(3))  dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct packed {
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic       illegal_op;
  } ctrl_t;

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic        z;
    logic [6:0]  op;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_cnt;
  int          checks = 0;
  int          errors = 0;

  function automatic logic is_illegal(input logic [6:0] op);
    logic ok;
    ok = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
         (op == 7'b0010011) || (op == 7'b1100011);
`ifdef MC_JAL_EN
    ok = ok || (op == 7'b1101111);
`endif
    return !ok;
  endfunction

  // Control word table written out state by state.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr, input logic z,
                                     input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      7'b0100011: c.imm_src = 2'b01;
      7'b1100011: c.imm_src = 2'b10;
      7'b1101111: c.imm_src = 2'b11;
      default:    c.imm_src = 2'b00;
    endcase
    case (st)
      4'd0:  begin c.ir_write = mr; c.pc_write = mr; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      4'd1:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.illegal_op = is_illegal(op); end
      4'd2:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      4'd3:  c.adr_src = 1'b1;
      4'd4:  begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      4'd5:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      4'd6:  begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      4'd7:  c.reg_write = 1'b1;
      4'd8:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      4'd9:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
      4'd10: begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_write = z; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic push_e(input logic [3:0] st, input logic mr, input logic z, input logic [6:0] op);
    exp_t e;
    e.st = st; e.mr = mr; e.z = z; e.op = op; e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  task automatic plan_instr(input logic [6:0] op, input logic z, input int fstall, input int mstall);
    for (int i = 0; i < fstall; i++) push_e(4'd0, 1'b0, z, op);
    push_e(4'd0, 1'b1, z, op);
    push_e(4'd1, 1'b0, z, op);
    if (!is_illegal(op)) begin
      case (op)
        7'b0000011: begin
          push_e(4'd2, 1'b0, z, op);
          for (int i = 0; i < mstall; i++) push_e(4'd3, 1'b0, z, op);
          push_e(4'd3, 1'b1, z, op);
          push_e(4'd4, 1'b0, z, op);
        end
        7'b0100011: begin
          push_e(4'd2, 1'b0, z, op);
          for (int i = 0; i < mstall; i++) push_e(4'd5, 1'b0, z, op);
          push_e(4'd5, 1'b1, z, op);
        end
        7'b0110011: begin push_e(4'd6, 1'b0, z, op); push_e(4'd7, 1'b0, z, op); end
        7'b0010011: begin push_e(4'd8, 1'b0, z, op); push_e(4'd7, 1'b0, z, op); end
        7'b1100011: push_e(4'd10, 1'b0, z, op);
        default:    begin push_e(4'd9, 1'b0, z, op); push_e(4'd7, 1'b0, z, op); end
      endcase
      model_cnt = model_cnt + 32'd1;
    end
  endtask

  task automatic run_queue();
    exp_t  e;
    ctrl_t obs, exp_c;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.op = e.op; bus.zero = e.z; bus.mem_ready = e.mr;
      @(negedge clk);
      exp_c = exp_ctrl(e.st, e.mr, e.z, e.op);
      obs = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
             bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src, bus.illegal_op};
      checks++;
      assert (bus.state_o === e.st) else begin
        errors++; $error("FAIL state op=%b obs=%0d exp=%0d", e.op, bus.state_o, e.st);
      end
      checks++;
      assert (obs === exp_c) else begin
        errors++; $error("FAIL ctrl st=%0d obs=%h exp=%h", e.st, obs, exp_c);
      end
      checks++;
      assert (bus.instret === e.cnt) else begin
        errors++; $error("FAIL instret st=%0d obs=%0d exp=%0d", e.st, bus.instret, e.cnt);
      end
      checks++;
      assert (bus3.instret === e.cnt[2:0]) else begin
        errors++; $error("FAIL instret3 st=%0d obs=%0d exp=%0d", e.st, bus3.instret, e.cnt[2:0]);
      end
      $display("cycle op=%b st=%0d mr=%0d z=%0d instret=%0d", e.op, bus.state_o, e.mr, e.z, bus.instret);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    model_cnt = 32'd0;
    reset = 1'b1; bus.op = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    assert (bus.state_o === 4'd0 && bus.instret === 32'd0 && bus.ir_write === 1'b0) else begin
      errors++; $error("FAIL reset state=%0d instret=%0d exp 0/0", bus.state_o, bus.instret);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    plan_instr(OP_LW,  1'b0, 0, 0); run_queue();
    plan_instr(OP_SW,  1'b0, 1, 3); run_queue();
    plan_instr(OP_BEQ, 1'b1, 0, 0); run_queue();
    plan_instr(OP_BEQ, 1'b0, 0, 0); run_queue();
    plan_instr(7'b1111111, 1'b0, 0, 0); run_queue();
    plan_instr(7'b0000000, 1'b1, 0, 0); run_queue();
    plan_instr(OP_JAL, 1'b0, 0, 0); run_queue();
    plan_instr(OP_LW,  1'b1, 2, 2); run_queue();
    for (int i = 0; i < 6; i++) begin
      plan_instr((i % 2 == 0) ? OP_R : OP_I, 1'(i % 3 == 0), 0, 0);
      run_queue();
    end

    // Abandon a load stalled in MEMREAD with a reset.
    push_e(4'd0, 1'b1, 1'b0, OP_LW);
    push_e(4'd1, 1'b0, 1'b0, OP_LW);
    push_e(4'd2, 1'b0, 1'b0, OP_LW);
    push_e(4'd3, 1'b0, 1'b0, OP_LW);
    run_queue();
    reset = 1'b1; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt = 32'd0;
    push_e(4'd0, 1'b0, 1'b0, OP_LW);
    run_queue();
    plan_instr(OP_R, 1'b0, 0, 0); run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
